// File: rtl/cnn_load_pkg.sv
// rtl/cnn_load_pkg.sv - shared op codes, FSM states and accelerator register map
package cnn_load_pkg;

  typedef enum logic [1:0] {
    OP_BURST    = 2'b00,
    OP_REG      = 2'b01,
    OP_WAIT_IRQ = 2'b10,
    OP_RSVD     = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BURST,
    ST_GAP,
    ST_REG,
    ST_WAIT_IRQ,
    ST_CLR,
    ST_FIN
  } state_e;

  // Accelerator register map as seen from the slave write channel
  localparam logic [31:0] REG_IMAGE_SET   = 32'h0000_0000;
  localparam logic [31:0] REG_INTERRUPT   = 32'h0000_0004;
  localparam logic [31:0] WIN_PIXEL_BASE  = 32'h0000_1000;
  localparam logic [31:0] WIN_WEIGHT_BASE = 32'h0001_0000;
  localparam logic [31:0] WIN_BIAS_BASE   = 32'h0002_0000;

endpackage

// File: rtl/cnn_load_if.sv
// rtl/cnn_load_if.sv - write channel and interrupt flag between load master and accelerator top
interface cnn_load_if;

  logic [31:0] awaddr;
  logic        awvalid;
  logic [31:0] wdata;
  logic        wvalid;
  logic        interrupt_signal;

  modport master (
    output awaddr,
    output awvalid,
    output wdata,
    output wvalid,
    input  interrupt_signal
  );

  modport slave (
    input  awaddr,
    input  awvalid,
    input  wdata,
    input  wvalid,
    output interrupt_signal
  );

endinterface

// File: rtl/cnn_load_beat_gen.sv
// rtl/cnn_load_beat_gen.sv - burst beat counter, address generator and inter-beat gap timer
module cnn_load_beat_gen #(
  parameter int unsigned ADDR_STRIDE = 4,
  parameter int unsigned GAP_CYCLES  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] base_addr,
  input  logic [15:0] len,
  input  logic        src_valid,
  input  logic        src_ready,
  output logic        beat_taken,
  output logic [31:0] beat_addr,
  output logic        last_beat,
  output logic        all_done,
  output logic        gap_last
);

  localparam logic [31:0] STRIDE = 32'(ADDR_STRIDE);
  localparam logic [3:0]  GAP    = 4'(GAP_CYCLES);

  logic [31:0] addr_q;
  logic [15:0] cnt_q;
  logic [15:0] len_q;
  logic [3:0]  gap_q;

  assign beat_taken = src_valid && src_ready;
  assign beat_addr  = addr_q;
  assign last_beat  = ((cnt_q + 16'd1) == len_q);
  assign all_done   = (cnt_q == len_q);
  // Gap counter is reloaded by each beat and counts down to 1 on the final idle cycle
  assign gap_last   = (gap_q <= 4'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      cnt_q  <= '0;
      len_q  <= '0;
      gap_q  <= '0;
    end else if (load) begin
      addr_q <= base_addr;
      cnt_q  <= '0;
      len_q  <= len;
      gap_q  <= '0;
    end else if (beat_taken) begin
      addr_q <= addr_q + STRIDE;
      cnt_q  <= cnt_q + 16'd1;
      gap_q  <= GAP;
    end else if (gap_q != 4'd0) begin
      gap_q  <= gap_q - 4'd1;
    end
  end

endmodule

// File: rtl/cnn_load_master.sv
// rtl/cnn_load_master.sv - host-side write initiator running BURST, REG and WAIT_IRQ commands
// Defining CNN_LOAD_CHECKSUM_EN adds a checksum output summing every emitted wdata.
module cnn_load_master
  import cnn_load_pkg::*;
#(
  parameter int unsigned ADDR_STRIDE    = 4,
  parameter int unsigned GAP_CYCLES     = 0,
  parameter logic [31:0] IRQ_CLR_ADDR   = REG_INTERRUPT,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [15:0] cmd_len,
  input  logic [31:0] cmd_data,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic [15:0] src_data,
  cnn_load_if.master  bus,
  output logic        busy,
  output logic        done,
`ifdef CNN_LOAD_CHECKSUM_EN
  output logic        timeout,
  output logic [31:0] checksum
`else
  output logic        timeout
`endif
);

  localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic        GAP_EN  = (GAP_CYCLES != 0);

  state_e      state_q, state_n;
  logic [31:0] wait_cnt_q;
  logic        to_q, to_set;
  logic        wr_en;
  logic [31:0] wr_addr, wr_data;
  logic [31:0] awaddr_q, wdata_q;
  logic        wvalid_q;
  logic        load;
  logic        beat_taken, last_beat, all_done, gap_last;
  logic [31:0] beat_addr;

  cnn_load_beat_gen #(
    .ADDR_STRIDE (ADDR_STRIDE),
    .GAP_CYCLES  (GAP_CYCLES)
  ) u_beat_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .base_addr  (cmd_addr),
    .len        (cmd_len),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .beat_taken (beat_taken),
    .beat_addr  (beat_addr),
    .last_beat  (last_beat),
    .all_done   (all_done),
    .gap_last   (gap_last)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  // The burst lingers in ST_BURST for one drained cycle so done trails the last write
  assign src_ready = (state_q == ST_BURST) && !all_done;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done      = (state_q == ST_FIN);
  assign timeout   = to_q;

  assign bus.awaddr  = awaddr_q;
  assign bus.wdata   = wdata_q;
  assign bus.awvalid = wvalid_q;
  assign bus.wvalid  = wvalid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    load    = 1'b0;
    to_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (op_e'(cmd_op))
            OP_BURST: begin
              load    = 1'b1;
              state_n = (cmd_len == 16'd0) ? ST_FIN : ST_BURST;
            end
            OP_REG: begin
              wr_en   = 1'b1;
              wr_addr = cmd_addr;
              wr_data = cmd_data;
              state_n = ST_REG;
            end
            OP_WAIT_IRQ: state_n = ST_WAIT_IRQ;
            default:     state_n = ST_FIN;
          endcase
        end
      end
      ST_BURST: begin
        if (all_done) begin
          state_n = ST_FIN;
        end else if (beat_taken) begin
          wr_en   = 1'b1;
          wr_addr = beat_addr;
          wr_data = {16'h0000, src_data};
          if (!last_beat && GAP_EN) state_n = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_last) state_n = ST_BURST;
      end
      ST_REG: state_n = ST_FIN;
      ST_WAIT_IRQ: begin
        // Interrupt is tested first so it wins a tie with the timeout
        if (bus.interrupt_signal) begin
          wr_en   = 1'b1;
          wr_addr = IRQ_CLR_ADDR;
          wr_data = '0;
          state_n = ST_CLR;
        end else if (TO_EN && (wait_cnt_q == TO_LAST)) begin
          to_set  = 1'b1;
          state_n = ST_FIN;
        end
      end
      ST_CLR:  state_n = ST_FIN;
      ST_FIN:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wvalid_q   <= 1'b0;
      wait_cnt_q <= '0;
      to_q       <= 1'b0;
    end else begin
      wvalid_q <= wr_en;
      if (wr_en) begin
        awaddr_q <= wr_addr;
        wdata_q  <= wr_data;
      end
      wait_cnt_q <= (state_q == ST_WAIT_IRQ) ? wait_cnt_q + 32'd1 : 32'd0;
      to_q       <= to_set;
    end
  end

`ifdef CNN_LOAD_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else if (load) begin
      sum_q <= '0;
    end else if (wr_en) begin
      sum_q <= sum_q + wr_data;
    end
  end

  assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_cnn_load_master.sv
// tb/tb_cnn_load_master.sv - directed self-checking bench for cnn_load_master
module tb_cnn_load_master;
  import cnn_load_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr, cmd_data;
  logic [15:0] cmd_len;
  logic        cmd_valid_a, cmd_valid_b, cmd_ready_a, cmd_ready_b;
  logic        src_valid;
  logic [15:0] src_data;
  logic        src_ready_a, src_ready_b;
  logic        busy_a, busy_b, done_a, done_b, timeout_a, timeout_b;
`ifdef CNN_LOAD_CHECKSUM_EN
  logic [31:0] cks_a, cks_b;
`endif

  cnn_load_if bus_a ();
  cnn_load_if bus_b ();

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          pair_bad = 0;
  wr_t         wq_a[$];
  wr_t         wq_b[$];
  logic [15:0] src_mem [32];
  int          src_rd = 0;
  int          src_wr = 0;
  bit          src_toggle = 1'b0;
  bit          src_phase = 1'b0;
  bit          src_take;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cnn_load_master #(.GAP_CYCLES(0)) u_a (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid_a),
    .cmd_ready (cmd_ready_a),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .src_valid (src_valid),
    .src_ready (src_ready_a),
    .src_data  (src_data),
    .bus       (bus_a),
    .busy      (busy_a),
    .done      (done_a),
`ifdef CNN_LOAD_CHECKSUM_EN
    .checksum  (cks_a),
`endif
    .timeout   (timeout_a)
  );

  cnn_load_master #(.GAP_CYCLES(2), .TIMEOUT_CYCLES(8)) u_b (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid_b),
    .cmd_ready (cmd_ready_b),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .src_valid (src_valid),
    .src_ready (src_ready_b),
    .src_data  (src_data),
    .bus       (bus_b),
    .busy      (busy_b),
    .done      (done_b),
`ifdef CNN_LOAD_CHECKSUM_EN
    .checksum  (cks_b),
`endif
    .timeout   (timeout_b)
  );

  // Write monitor: every visible write is logged with its cycle stamp
  always @(negedge clk) begin
    if (bus_a.awvalid || bus_a.wvalid) begin
      if (bus_a.awvalid !== bus_a.wvalid) pair_bad <= pair_bad + 1;
      wq_a.push_back('{bus_a.awaddr, bus_a.wdata, cyc});
    end
    if (bus_b.awvalid || bus_b.wvalid) begin
      wq_b.push_back('{bus_b.awaddr, bus_b.wdata, cyc});
    end
  end

  // Source model: presents src_mem[src_rd..src_wr-1], optionally every other cycle
  initial begin
    src_valid = 1'b0;
    src_data  = 16'h0;
    forever begin
      @(negedge clk);
      src_take = src_valid && (src_ready_a || src_ready_b);
      @(posedge clk);
      #1;
      if (src_take) src_rd++;
      src_phase = !src_phase;
      src_valid = (src_rd < src_wr) && (!src_toggle || src_phase);
      src_data  = (src_rd < src_wr) ? src_mem[src_rd] : 16'h0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_src(input logic [15:0] w);
    src_mem[src_wr] = w;
    src_wr++;
  endtask

  task automatic send_cmd(input bit sel, input logic [1:0] op, input logic [31:0] addr,
                          input logic [15:0] len, input logic [31:0] data, output int acc);
    @(negedge clk);
    check(sel ? "cmd_ready_b" : "cmd_ready_a", 32'(sel ? cmd_ready_b : cmd_ready_a), 32'd1);
    cmd_op   = op;
    cmd_addr = addr;
    cmd_len  = len;
    cmd_data = data;
    if (sel) cmd_valid_b = 1'b1;
    else     cmd_valid_a = 1'b1;
    @(posedge clk);
    #1;
    acc         = cyc;
    cmd_valid_a = 1'b0;
    cmd_valid_b = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int max_cyc, output int dcyc, output logic to);
    dcyc = -1;
    to   = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if ((sel ? done_b : done_a) === 1'b1) begin
        dcyc = cyc;
        to   = sel ? timeout_b : timeout_a;
        break;
      end
    end
    check(sel ? "done_seen_b" : "done_seen_a", 32'(dcyc >= 0), 32'd1);
  endtask

  initial begin
    int          acc, dc, n0;
    logic        to;
    logic [31:0] exp_b[3];

    rst = 1'b0;
    cmd_valid_a = 1'b0;
    cmd_valid_b = 1'b0;
    cmd_op = 2'b00;
    cmd_addr = '0;
    cmd_len = '0;
    cmd_data = '0;
    bus_a.interrupt_signal = 1'b0;
    bus_b.interrupt_signal = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_awaddr",  bus_a.awaddr, 32'h0);
    check("rst_wdata",   bus_a.wdata, 32'h0);
    check("rst_awvalid", 32'(bus_a.awvalid), 32'd0);
    check("rst_wvalid",  32'(bus_a.wvalid), 32'd0);
    check("rst_busy",    32'(busy_a), 32'd0);
    check("rst_done",    32'(done_a), 32'd0);
    check("rst_timeout", 32'(timeout_a), 32'd0);
    check("rst_src_rdy", 32'(src_ready_a), 32'd0);
    check("rst_cmd_rdy", 32'(cmd_ready_b), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Burst of 3, source always valid, no gap
    n0 = wq_a.size();
    push_src(16'h00A1);
    push_src(16'h00A2);
    push_src(16'h00A3);
    send_cmd(1'b0, OP_BURST, 32'h0000_1000, 16'd3, 32'h0, acc);
    wait_done(1'b0, 100, dc, to);
    check("t1_nwr", wq_a.size() - n0, 32'd3);
    for (int i = 0; i < 3 && n0 + i < wq_a.size(); i++) begin
      check("t1_addr", wq_a[n0+i].addr, 32'h0000_1000 + 32'(4 * i));
      check("t1_data", wq_a[n0+i].data, 32'h0000_00A1 + 32'(i));
      check("t1_cyc",  wq_a[n0+i].cyc, acc + 1 + i);
    end
    check("t1_done_cyc", dc, acc + 4);
    check("t1_timeout", 32'(to), 32'd0);

    // Same burst on the GAP_CYCLES=2 instance with a toggling source
    n0 = wq_b.size();
    src_toggle = 1'b1;
    push_src(16'h00B1);
    push_src(16'h00B2);
    push_src(16'h00B3);
    exp_b = '{32'h0000_00B1, 32'h0000_00B2, 32'h0000_00B3};
    send_cmd(1'b1, OP_BURST, 32'h0000_2000, 16'd3, 32'h0, acc);
    wait_done(1'b1, 200, dc, to);
    check("t2_nwr", wq_b.size() - n0, 32'd3);
    for (int i = 0; i < 3 && n0 + i < wq_b.size(); i++) begin
      check("t2_addr", wq_b[n0+i].addr, 32'h0000_2000 + 32'(4 * i));
      check("t2_data", wq_b[n0+i].data, exp_b[i]);
      if (i > 0) check("t2_gap", 32'((wq_b[n0+i].cyc - wq_b[n0+i-1].cyc) >= 3), 32'd1);
    end
    if (wq_b.size() == n0 + 3) check("t2_done_cyc", dc, wq_b[n0+2].cyc + 1);
    check("t2_src_left", src_wr - src_rd, 32'd0);
    src_toggle = 1'b0;

    // Single register write
    n0 = wq_a.size();
    send_cmd(1'b0, OP_REG, 32'h0, 16'd0, 32'h3, acc);
    wait_done(1'b0, 20, dc, to);
    check("t3_nwr", wq_a.size() - n0, 32'd1);
    if (wq_a.size() > n0) begin
      check("t3_addr", wq_a[n0].addr, 32'h0);
      check("t3_data", wq_a[n0].data, 32'h3);
      check("t3_cyc",  wq_a[n0].cyc, acc);
    end
    check("t3_done_cyc", dc, acc + 1);

    // Zero-length burst and reserved op: done without any write
    n0 = wq_a.size();
    send_cmd(1'b0, OP_BURST, 32'h0000_1000, 16'd0, 32'h0, acc);
    wait_done(1'b0, 20, dc, to);
    check("t4_len0_done_cyc", dc, acc);
    send_cmd(1'b0, OP_RSVD, 32'h0000_1000, 16'd5, 32'h0, acc);
    wait_done(1'b0, 20, dc, to);
    check("t4_rsvd_done_cyc", dc, acc);
    check("t4_nwr", wq_a.size() - n0, 32'd0);

    // Interrupt arrives 20 cycles into WAIT_IRQ
    n0 = wq_a.size();
    send_cmd(1'b0, OP_WAIT_IRQ, 32'h0, 16'd0, 32'h0, acc);
    repeat (20) @(negedge clk);
    bus_a.interrupt_signal = 1'b1;
    wait_done(1'b0, 20, dc, to);
    bus_a.interrupt_signal = 1'b0;
    check("t5_nwr", wq_a.size() - n0, 32'd1);
    if (wq_a.size() > n0) begin
      check("t5_addr", wq_a[n0].addr, 32'h0000_0004);
      check("t5_data", wq_a[n0].data, 32'h0);
      check("t5_cyc",  wq_a[n0].cyc, acc + 20);
    end
    check("t5_done_cyc", dc, acc + 21);
    check("t5_timeout", 32'(to), 32'd0);

    // No interrupt on the TIMEOUT_CYCLES=8 instance
    n0 = wq_b.size();
    send_cmd(1'b1, OP_WAIT_IRQ, 32'h0, 16'd0, 32'h0, acc);
    wait_done(1'b1, 50, dc, to);
    check("t6_done_cyc", dc, acc + 8);
    check("t6_timeout", 32'(to), 32'd1);
    check("t6_nwr", wq_b.size() - n0, 32'd0);

`ifdef CNN_LOAD_CHECKSUM_EN
    push_src(16'hFFFF);
    push_src(16'hFFFF);
    send_cmd(1'b0, OP_BURST, 32'h0000_1000, 16'd2, 32'h0, acc);
    wait_done(1'b0, 50, dc, to);
    check("t7_checksum", cks_a, 32'h0001_FFFE);
`endif

    // Reset asserted while beat 1 of a 4-beat burst is on the bus
    n0 = wq_a.size();
    push_src(16'h00C1);
    push_src(16'h00C2);
    push_src(16'h00C3);
    push_src(16'h00C4);
    send_cmd(1'b0, OP_BURST, WIN_PIXEL_BASE, 16'd4, 32'h0, acc);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (wq_a.size() - n0 >= 2) break;
    end
    check("t8_nwr_before", wq_a.size() - n0, 32'd2);
    rst = 1'b0;
    #1;
    check("t8_awvalid", 32'(bus_a.awvalid), 32'd0);
    check("t8_wvalid",  32'(bus_a.wvalid), 32'd0);
    check("t8_busy",    32'(busy_a), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("t8_nwr_after", wq_a.size() - n0, 32'd2);
    check("t8_cmd_ready", 32'(cmd_ready_a), 32'd1);
    check("t8_src_ready", 32'(src_ready_a), 32'd0);

    check("aw_w_pair", pair_bad, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
